// File: rtl/rt_request_initiator.sv
// Request/grant initiator: bounded-wait requests up to a transaction budget.
// Optional single retry per transaction when RT_INIT_RETRY_EN is defined.
module rt_request_initiator #(
  parameter int BUDGET   = 3,
  parameter int MAX_WAIT = 2,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ack,
  output logic          req,
  output logic          rt_get,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] served
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DONE  = 3'd2,
    S_ERR   = 3'd3,
    S_RETRY = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT);
  localparam logic [CW-1:0] LAST_TXN  = CW'(BUDGET - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] served_q;
  logic          timeout;
  logic          last_txn;
  logic          in_req;

  assign in_req   = (state_q == S_REQ);
  assign timeout  = (wait_q == LAST_WAIT);
  assign last_txn = (served_q == LAST_TXN);

`ifdef RT_INIT_RETRY_EN
  logic retried_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retried_q <= 1'b0;
    end else if (in_req && ack) begin
      retried_q <= 1'b0;
    end else if (in_req && timeout) begin
      retried_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      served_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_req && !ack && !timeout) begin
        wait_q <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
      // served only moves on an ack in REQ, so it stops at BUDGET
      if (in_req && ack) begin
        served_q <= served_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ack) begin
          state_d = S_ERR;
        end else if (start) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          state_d = last_txn ? S_DONE : S_IDLE;
        end else if (timeout) begin
`ifdef RT_INIT_RETRY_EN
          state_d = retried_q ? S_ERR : S_RETRY;
`else
          state_d = S_ERR;
`endif
        end
      end
      S_DONE: begin
        if (ack || start) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
`ifdef RT_INIT_RETRY_EN
      S_RETRY: begin
        state_d = ack ? S_ERR : S_REQ;
      end
`endif
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_comb begin
    req   = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    unique case (1'b1)
      (state_q == S_REQ): begin
        req  = 1'b1;
        busy = 1'b1;
      end
      (state_q == S_RETRY): busy  = 1'b1;
      (state_q == S_DONE):  done  = 1'b1;
      (state_q == S_ERR):   error = 1'b1;
      default: ;
    endcase
  end

  assign rt_get = req;
  assign served = served_q;

endmodule

// File: tb/tb_rt_request_initiator.sv
// Random and directed stimulus against a transaction-level model.
// Define RT_INIT_RETRY_EN to exercise the retry build.
module tb_rt_request_initiator;

  localparam int BUDGET   = 3;
  localparam int MAX_WAIT = 2;
  localparam int CW       = 3;

  logic          clk = 1'b0;
  logic          rst, start, ack;
  logic          req, rt_get, busy, done, error;
  logic [CW-1:0] served;

  rt_request_initiator #(
    .BUDGET(BUDGET), .MAX_WAIT(MAX_WAIT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .req(req), .rt_get(rt_get), .busy(busy),
    .done(done), .error(error), .served(served)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: request phase, retry gap, terminal flags
  bit m_active, m_gap, m_fin, m_err, m_retried;
  int m_held, m_served;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit a);
    if (r) begin
      m_active = 0; m_gap = 0; m_fin = 0; m_err = 0;
      m_retried = 0; m_held = 0; m_served = 0;
    end else if (m_err) begin
    end else if (m_fin) begin
      if (a || s) begin m_fin = 0; m_err = 1; end
    end else if (m_gap) begin
      m_gap = 0;
      if (a) m_err = 1;
      else begin m_active = 1; m_held = 0; end
    end else if (m_active) begin
      if (a) begin
        m_served++;
        m_active = 0; m_retried = 0;
        if (m_served == BUDGET) m_fin = 1;
      end else if (m_held == MAX_WAIT) begin
        m_active = 0;
`ifdef RT_INIT_RETRY_EN
        if (m_retried) m_err = 1;
        else begin m_gap = 1; m_retried = 1; end
`else
        m_err = 1;
`endif
      end else begin
        m_held++;
      end
    end else begin
      if (a) m_err = 1;
      else if (s) begin m_active = 1; m_held = 0; end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit a);
    rst = r; start = s; ack = a;
    @(posedge clk);
    model_step(r, s, a);
    #1;
    chk("req", int'(req), int'(m_active));
    chk("rt_get", int'(rt_get), int'(m_active));
    chk("busy", int'(busy), int'(m_active | m_gap));
    chk("done", int'(done), int'(m_fin));
    chk("error", int'(error), int'(m_err));
    chk("served", int'(served), m_served);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    m_active = 0; m_gap = 0; m_fin = 0; m_err = 0;
    m_retried = 0; m_held = 0; m_served = 0;

    // reset and idle
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    chk("idle_srv", int'(served), 0);

    // one transaction, ack on 2nd req cycle
    cyc(0, 1, 0);
    chk("t2_req1", int'(req), 1);
    cyc(0, 0, 0);
    chk("t2_req2", int'(req), 1);
    cyc(0, 0, 1);
    chk("t2_srv", int'(served), 1);
    chk("t2_req0", int'(req), 0);

    // two more with immediate ack -> DONE, then start past budget
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 1);
    end
    chk("bud_srv", int'(served), BUDGET);
    chk("bud_done", int'(done), 1);
    cyc(0, 1, 0);
    chk("past_err", int'(error), 1);
    chk("past_done", int'(done), 0);

    // timeout: req held MAX_WAIT+1 cycles
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("to_req3", int'(req), 1);
    cyc(0, 0, 0);
    chk("to_req", int'(req), 0);
    chk("to_srv", int'(served), 0);
`ifdef RT_INIT_RETRY_EN
    chk("to_busy", int'(busy), 1);
    cyc(0, 0, 0);
    chk("rt_req", int'(req), 1);
    cyc(0, 0, 1);
    chk("rt_srv", int'(served), 1);
    chk("rt_err", int'(error), 0);
    // no ack at all: two full windows then error
    cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rt2_req", int'(req), 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0);
    chk("rt2_pre", int'(error), 0);
    cyc(0, 0, 0);
    chk("rt2_err", int'(error), 1);
`else
    chk("to_err", int'(error), 1);
`endif

    // spurious ack in idle, then reset and recover
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("sp_err", int'(error), 1);
    cyc(1, 0, 0);
    chk("rst_err", int'(error), 0);
    chk("rst_srv", int'(served), 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("rec_srv", int'(served), 1);
    chk("rec_err", int'(error), 0);

    // random traffic, ack biased toward active requests
    for (int i = 0; i < 3000; i++) begin
      bit r, s, a;
      r = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) < 40);
      if (m_active) a = ($urandom_range(0, 99) < 45);
      else a = ($urandom_range(0, 99) < 3);
      cyc(r, s, a);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
